// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: EXE-stage sequencer for the signed/unsigned AXI-Stream divider cores.
// Issues each divide exactly once, stalls EXE until the result is back, and
// drains an in-flight core transaction cleanly when the instruction is flushed.
module exe_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic [3:0]  es_div_op,
    input  logic [31:0] es_src1,
    input  logic [31:0] es_src2,
    input  logic        ms_allowin,

    output logic [31:0] div_dividend_tdata,
    output logic [31:0] div_divisor_tdata,

    output logic        sdiv_dividend_tvalid,
    output logic        sdiv_divisor_tvalid,
    input  logic        sdiv_dividend_tready,
    input  logic        sdiv_divisor_tready,
    input  logic        sdiv_dout_tvalid,
    input  logic [63:0] sdiv_dout_tdata,

    output logic        udiv_dividend_tvalid,
    output logic        udiv_divisor_tvalid,
    input  logic        udiv_dividend_tready,
    input  logic        udiv_divisor_tready,
    input  logic        udiv_dout_tvalid,
    input  logic [63:0] udiv_dout_tdata,

    output logic        div_ready_go,
    output logic [31:0] div_result,
    output logic        div_busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DOUT_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;

    // Latched per-instruction controls.
    logic sel_signed;
    logic want_rem;

    // Decode of the op currently sitting in EXE: {div_w, mod_w, div_wu, mod_wu}.
    logic is_div;
    logic op_signed;
    logic op_rem;

    assign is_div    = es_valid & (|es_div_op);
    assign op_signed = es_div_op[3] | es_div_op[2];
    assign op_rem    = es_div_op[2] | es_div_op[0];

    // View of whichever core this instruction was issued to.
    logic              sel_dd_valid;
    logic              sel_dv_valid;
    logic              sel_dd_ready;
    logic              sel_dv_ready;
    logic              sel_dout_valid;
    logic [DOUT_W-1:0] sel_dout_data;

    assign sel_dd_valid   = sel_signed ? sdiv_dividend_tvalid : udiv_dividend_tvalid;
    assign sel_dv_valid   = sel_signed ? sdiv_divisor_tvalid  : udiv_divisor_tvalid;
    assign sel_dd_ready   = sel_signed ? sdiv_dividend_tready : udiv_dividend_tready;
    assign sel_dv_ready   = sel_signed ? sdiv_divisor_tready  : udiv_divisor_tready;
    assign sel_dout_valid = sel_signed ? sdiv_dout_tvalid     : udiv_dout_tvalid;
    assign sel_dout_data  = sel_signed ? sdiv_dout_tdata      : udiv_dout_tdata;

    // Input channels still pending after this cycle's handshakes.
    logic dd_pending_next;
    logic dv_pending_next;
    logic inputs_done;

    assign dd_pending_next = sel_dd_valid & ~sel_dd_ready;
    assign dv_pending_next = sel_dv_valid & ~sel_dv_ready;
    assign inputs_done     = ~dd_pending_next & ~dv_pending_next;

    // Quotient sits in the upper half of the core output, remainder in the lower.
    logic [DATA_W-1:0] picked_result;

    assign picked_result = want_rem ? sel_dout_data[DATA_W-1:0]
                                    : sel_dout_data[DOUT_W-1:DATA_W];

    // EXE may advance for non-divides at once, and for divides only in DONE.
    assign div_ready_go = ~is_div | (state == S_DONE);

    // Control FSM with registered operands, tvalids, result and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            sel_signed           <= 1'b0;
            want_rem             <= 1'b0;
            div_dividend_tdata   <= '0;
            div_divisor_tdata    <= '0;
            sdiv_dividend_tvalid <= 1'b0;
            sdiv_divisor_tvalid  <= 1'b0;
            udiv_dividend_tvalid <= 1'b0;
            udiv_divisor_tvalid  <= 1'b0;
            div_result           <= '0;
            div_busy             <= 1'b0;
        end else begin
            // Each channel's tvalid retires on its own handshake, in any state.
            if (sdiv_dividend_tvalid && sdiv_dividend_tready) sdiv_dividend_tvalid <= 1'b0;
            if (sdiv_divisor_tvalid  && sdiv_divisor_tready)  sdiv_divisor_tvalid  <= 1'b0;
            if (udiv_dividend_tvalid && udiv_dividend_tready) udiv_dividend_tvalid <= 1'b0;
            if (udiv_divisor_tvalid  && udiv_divisor_tready)  udiv_divisor_tvalid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        state                <= S_SEND;
                        div_busy             <= 1'b1;
                        div_dividend_tdata   <= es_src1;
                        div_divisor_tdata    <= es_src2;
                        sel_signed           <= op_signed;
                        want_rem             <= op_rem;
                        sdiv_dividend_tvalid <= op_signed;
                        sdiv_divisor_tvalid  <= op_signed;
                        udiv_dividend_tvalid <= ~op_signed;
                        udiv_divisor_tvalid  <= ~op_signed;
                    end
                end

                S_SEND: begin
                    if (!es_valid) begin
                        state <= S_DRAIN;
                    end else if (inputs_done) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sel_dout_valid) begin
                        if (es_valid) begin
                            div_result <= picked_result;
                            state      <= S_DONE;
                        end else begin
                            // Flushed in the very cycle the result arrived: drop it.
                            state    <= S_IDLE;
                            div_busy <= 1'b0;
                        end
                    end else if (!es_valid) begin
                        state <= S_DRAIN;
                    end
                end

                S_DONE: begin
                    // A flush here would otherwise leave DONE waiting for a leave that never comes.
                    if (ms_allowin || !es_valid) begin
                        state    <= S_IDLE;
                        div_busy <= 1'b0;
                    end
                end

                S_DRAIN: begin
                    if (!sel_dd_valid && !sel_dv_valid && sel_dout_valid) begin
                        state    <= S_IDLE;
                        div_busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    div_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_div_ctrl.sv
// tb_exe_div_ctrl: directed bench for exe_div_ctrl with two behavioural divider cores.
module tb_exe_div_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_valid;
    logic [3:0]  es_div_op;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        ms_allowin;
    logic [31:0] div_dividend_tdata;
    logic [31:0] div_divisor_tdata;
    logic        sdiv_dividend_tvalid;
    logic        sdiv_divisor_tvalid;
    logic        sdiv_dividend_tready;
    logic        sdiv_divisor_tready;
    logic        sdiv_dout_tvalid;
    logic [63:0] sdiv_dout_tdata;
    logic        udiv_dividend_tvalid;
    logic        udiv_divisor_tvalid;
    logic        udiv_dividend_tready;
    logic        udiv_divisor_tready;
    logic        udiv_dout_tvalid;
    logic [63:0] udiv_dout_tdata;
    logic        div_ready_go;
    logic [31:0] div_result;
    logic        div_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    exe_div_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .es_valid             (es_valid),
        .es_div_op            (es_div_op),
        .es_src1              (es_src1),
        .es_src2              (es_src2),
        .ms_allowin           (ms_allowin),
        .div_dividend_tdata   (div_dividend_tdata),
        .div_divisor_tdata    (div_divisor_tdata),
        .sdiv_dividend_tvalid (sdiv_dividend_tvalid),
        .sdiv_divisor_tvalid  (sdiv_divisor_tvalid),
        .sdiv_dividend_tready (sdiv_dividend_tready),
        .sdiv_divisor_tready  (sdiv_divisor_tready),
        .sdiv_dout_tvalid     (sdiv_dout_tvalid),
        .sdiv_dout_tdata      (sdiv_dout_tdata),
        .udiv_dividend_tvalid (udiv_dividend_tvalid),
        .udiv_divisor_tvalid  (udiv_divisor_tvalid),
        .udiv_dividend_tready (udiv_dividend_tready),
        .udiv_divisor_tready  (udiv_divisor_tready),
        .udiv_dout_tvalid     (udiv_dout_tvalid),
        .udiv_dout_tdata      (udiv_dout_tdata),
        .div_ready_go         (div_ready_go),
        .div_result           (div_result),
        .div_busy             (div_busy)
    );

    // ---------------- divider core models (index 0 signed, 1 unsigned) ----------------
    int          dd_delay = 0;
    int          dv_delay = 0;
    logic [1:0]  m_dd_v, m_dv_v, m_dd_r, m_dv_r, m_out_v, hs_a, hs_b;
    logic [63:0] m_out_d [2];
    logic [31:0] m_a [2];
    logic [31:0] m_b [2];
    logic        m_have_a [2];
    logic        m_have_b [2];
    logic        m_busy [2];
    int          m_cnt [2];
    int          m_dd_wait [2];
    int          m_dv_wait [2];
    int          dd_hs_n [2] = '{0, 0};
    int          dv_hs_n [2] = '{0, 0};

    assign m_dd_v = {udiv_dividend_tvalid, sdiv_dividend_tvalid};
    assign m_dv_v = {udiv_divisor_tvalid, sdiv_divisor_tvalid};
    assign hs_a   = m_dd_v & m_dd_r;
    assign hs_b   = m_dv_v & m_dv_r;
    assign sdiv_dividend_tready = m_dd_r[0];
    assign sdiv_divisor_tready  = m_dv_r[0];
    assign udiv_dividend_tready = m_dd_r[1];
    assign udiv_divisor_tready  = m_dv_r[1];
    assign sdiv_dout_tvalid     = m_out_v[0];
    assign udiv_dout_tvalid     = m_out_v[1];
    assign sdiv_dout_tdata      = m_out_d[0];
    assign udiv_dout_tdata      = m_out_d[1];

    function automatic logic [63:0] calc(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {q, r};
        end
        return {a / b, a % b};
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            m_dd_r[k]  = (m_dd_wait[k] >= dd_delay);
            m_dv_r[k]  = (m_dv_wait[k] >= dv_delay);
            m_out_v[k] = m_busy[k] && (m_cnt[k] == 1);
            m_out_d[k] = calc(k == 0, m_a[k], m_b[k]);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_have_a[k]  <= 1'b0;
                m_have_b[k]  <= 1'b0;
                m_busy[k]    <= 1'b0;
                m_cnt[k]     <= 0;
                m_dd_wait[k] <= 0;
                m_dv_wait[k] <= 0;
                m_a[k]       <= 32'd0;
                m_b[k]       <= 32'd0;
            end else begin
                if (hs_a[k]) begin
                    m_a[k]       <= div_dividend_tdata;
                    m_have_a[k]  <= 1'b1;
                    dd_hs_n[k]   <= dd_hs_n[k] + 1;
                    m_dd_wait[k] <= 0;
                end else if (m_dd_v[k]) m_dd_wait[k] <= m_dd_wait[k] + 1;
                else m_dd_wait[k] <= 0;
                if (hs_b[k]) begin
                    m_b[k]       <= div_divisor_tdata;
                    m_have_b[k]  <= 1'b1;
                    dv_hs_n[k]   <= dv_hs_n[k] + 1;
                    m_dv_wait[k] <= 0;
                end else if (m_dv_v[k]) m_dv_wait[k] <= m_dv_wait[k] + 1;
                else m_dv_wait[k] <= 0;
                if (m_busy[k]) begin
                    m_cnt[k] <= m_cnt[k] - 1;
                    if (m_cnt[k] == 1) m_busy[k] <= 1'b0;
                end else if ((m_have_a[k] || hs_a[k]) && (m_have_b[k] || hs_b[k])) begin
                    m_busy[k]   <= 1'b1;
                    m_cnt[k]    <= LAT;
                    m_have_a[k] <= 1'b0;
                    m_have_b[k] <= 1'b0;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    int         s_tv_cyc = 0;
    int         u_tv_cyc = 0;
    int         sdd_cyc  = 0;
    int         sdv_cyc  = 0;
    int         axi_viol = 0;
    logic [3:0] prev_v   = 4'd0;
    logic [3:0] prev_r   = 4'd0;
    logic       prev_rst = 1'b1;

    always @(posedge clk) begin
        logic [3:0] cur_v;
        cur_v = {udiv_divisor_tvalid, udiv_dividend_tvalid, sdiv_divisor_tvalid, sdiv_dividend_tvalid};
        if (sdiv_dividend_tvalid || sdiv_divisor_tvalid) s_tv_cyc++;
        if (udiv_dividend_tvalid || udiv_divisor_tvalid) u_tv_cyc++;
        if (sdiv_dividend_tvalid) sdd_cyc++;
        if (sdiv_divisor_tvalid)  sdv_cyc++;
        if (!prev_rst && ((prev_v & ~prev_r & ~cur_v) != 4'd0)) axi_viol++;
        prev_v   = cur_v;
        prev_r   = {udiv_divisor_tready, udiv_dividend_tready, sdiv_divisor_tready, sdiv_dividend_tready};
        prev_rst = reset;
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        es_valid  = 1'b1;
        es_div_op = op;
        es_src1   = a;
        es_src2   = b;
        cyc = 0;
        #1;
        while (!div_ready_go && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic leave();
        @(negedge clk);
        es_valid  = 1'b0;
        es_div_op = 4'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; es_valid = 1'b0; es_div_op = 4'd0; es_src1 = '0; es_src2 = '0; ms_allowin = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (div_ready_go !== 1'b1) begin fails++; $display("FAIL reset_ready_go: got %b expected 1", div_ready_go); end
        checks++;
        if ({sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid} !== 4'b0000) begin
            fails++; $display("FAIL reset_tvalids: got %b%b%b%b expected 0000", sdiv_dividend_tvalid,
                              sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid);
        end
        checks++;
        if ({div_dividend_tdata, div_divisor_tdata} !== 64'd0) begin
            fails++; $display("FAIL reset_tdata: got %h/%h expected 0/0", div_dividend_tdata, div_divisor_tdata);
        end
        checks++;
        if (div_result !== 32'd0 || div_busy !== 1'b0) begin
            fails++; $display("FAIL reset_result_busy: got %h/%b expected 0/0", div_result, div_busy);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_signed();
        int cyc;
        int u0;
        u0 = u_tv_cyc;
        run_div(4'b1000, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (cyc !== 6) begin fails++; $display("FAIL div_w_latency: got %0d expected 6", cyc); end
        checks++;
        if (div_result !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_w_result: got %h expected fffffffd", div_result); end
        leave();
        run_div(4'b0100, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (div_result !== 32'hFFFF_FFFF || cyc !== 6) begin
            fails++; $display("FAIL mod_w_result: got %h after %0d expected ffffffff after 6", div_result, cyc);
        end
        leave();
        checks++;
        if (u_tv_cyc !== u0) begin fails++; $display("FAIL signed_udiv_idle: got %0d udiv valid cycles expected 0", u_tv_cyc - u0); end
    endtask

    task automatic test_unsigned();
        int cyc;
        int s0;
        s0 = s_tv_cyc;
        run_div(4'b0010, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (div_result !== 32'h7FFF_FFFC || cyc !== 6) begin
            fails++; $display("FAIL div_wu_result: got %h after %0d expected 7ffffffc after 6", div_result, cyc);
        end
        leave();
        run_div(4'b0001, 32'hFFFF_FFF9, 32'd2, cyc);
        checks++;
        if (div_result !== 32'h0000_0001) begin fails++; $display("FAIL mod_wu_result: got %h expected 00000001", div_result); end
        leave();
        checks++;
        if (s_tv_cyc !== s0) begin fails++; $display("FAIL unsigned_sdiv_idle: got %0d sdiv valid cycles expected 0", s_tv_cyc - s0); end
    endtask

    task automatic test_staggered();
        int cyc;
        int a0, b0, ha, hb;
        a0 = sdd_cyc; b0 = sdv_cyc; ha = dd_hs_n[0]; hb = dv_hs_n[0];
        dd_delay = 3;
        run_div(4'b1000, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 9 || div_result !== 32'd14) begin
            fails++; $display("FAIL stagger_result: got %h after %0d expected 0000000e after 9", div_result, cyc);
        end
        leave();
        dd_delay = 0;
        checks++;
        if (sdd_cyc - a0 !== 4 || sdv_cyc - b0 !== 1) begin
            fails++; $display("FAIL stagger_valid_len: got dd=%0d dv=%0d expected dd=4 dv=1", sdd_cyc - a0, sdv_cyc - b0);
        end
        checks++;
        if (dd_hs_n[0] - ha !== 1 || dv_hs_n[0] - hb !== 1) begin
            fails++; $display("FAIL stagger_hs_count: got dd=%0d dv=%0d expected 1/1", dd_hs_n[0] - ha, dv_hs_n[0] - hb);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int h0;
        h0 = dd_hs_n[1];
        ms_allowin = 1'b0;
        run_div(4'b0010, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 6 || div_result !== 32'd14) begin
            fails++; $display("FAIL bp_first_result: got %h after %0d expected 0000000e after 6", div_result, cyc);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (div_ready_go !== 1'b1 || div_result !== 32'd14) begin
                fails++; $display("FAIL bp_hold_%0d: got go=%b res=%h expected go=1 res=0000000e", i, div_ready_go, div_result);
            end
        end
        checks++;
        if (dd_hs_n[1] - h0 !== 1) begin fails++; $display("FAIL bp_no_reissue: got %0d issues expected 1", dd_hs_n[1] - h0); end
        ms_allowin = 1'b1;
        @(negedge clk);
        es_div_op = 4'b0001;
        #1;
        checks++;
        if (div_busy !== 1'b0 || udiv_dividend_tvalid !== 1'b0 || div_ready_go !== 1'b0) begin
            fails++; $display("FAIL b2b_idle: got busy=%b tv=%b go=%b expected 0/0/0", div_busy, udiv_dividend_tvalid, div_ready_go);
        end
        @(negedge clk);
        checks++;
        if (udiv_dividend_tvalid !== 1'b1 || udiv_divisor_tvalid !== 1'b1) begin
            fails++; $display("FAIL b2b_issue: got %b%b expected 11", udiv_dividend_tvalid, udiv_divisor_tvalid);
        end
        cyc = 1;
        while (!div_ready_go && cyc < 60) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc !== 6 || div_result !== 32'd2) begin
            fails++; $display("FAIL b2b_second_result: got %h after %0d expected 00000002 after 6", div_result, cyc);
        end
        leave();
        es_valid = 1'b1; es_div_op = 4'd0;
        #1;
        checks++;
        if (div_ready_go !== 1'b1) begin fails++; $display("FAIL nondiv_ready_go: got %b expected 1", div_ready_go); end
        @(negedge clk);
        es_valid = 1'b0;
    endtask

    task automatic test_flush();
        int cyc;
        es_valid = 1'b1; es_div_op = 4'b1000; es_src1 = 32'd100; es_src2 = 32'd7;
        repeat (2) @(negedge clk);
        es_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b1 || div_ready_go !== 1'b1) begin
            fails++; $display("FAIL flush_drain: got busy=%b go=%b expected 1/1", div_busy, div_ready_go);
        end
        @(negedge clk);
        es_valid = 1'b1; es_div_op = 4'b0010; es_src1 = 32'hFFFF_FFF9; es_src2 = 32'd2;
        #1;
        checks++;
        if (div_ready_go !== 1'b0) begin fails++; $display("FAIL flush_new_stall: got %b expected 0", div_ready_go); end
        @(negedge clk);
        checks++;
        if (udiv_dividend_tvalid !== 1'b0) begin fails++; $display("FAIL flush_no_early_issue: got %b expected 0", udiv_dividend_tvalid); end
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0 || div_result !== 32'd2 || udiv_dividend_tvalid !== 1'b0) begin
            fails++; $display("FAIL flush_idle: got busy=%b res=%h tv=%b expected 0/00000002/0", div_busy, div_result, udiv_dividend_tvalid);
        end
        cyc = 0;
        while (!div_ready_go && cyc < 60) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc !== 6 || div_result !== 32'h7FFF_FFFC) begin
            fails++; $display("FAIL flush_next_result: got %h after %0d expected 7ffffffc after 6", div_result, cyc);
        end
        leave();
    endtask

    task automatic test_reset_wait();
        int cyc;
        es_valid = 1'b1; es_div_op = 4'b1000; es_src1 = 32'd100; es_src2 = 32'd7;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sdiv_dividend_tvalid, sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid} !== 4'b0000
            || div_busy !== 1'b0 || div_result !== 32'd0) begin
            fails++; $display("FAIL reset_wait_state: got tv=%b%b%b%b busy=%b res=%h expected 0000/0/0", sdiv_dividend_tvalid,
                              sdiv_divisor_tvalid, udiv_dividend_tvalid, udiv_divisor_tvalid, div_busy, div_result);
        end
        reset = 1'b0; es_valid = 1'b0;
        @(negedge clk);
        run_div(4'b0010, 32'd100, 32'd7, cyc);
        checks++;
        if (cyc !== 6 || div_result !== 32'd14) begin
            fails++; $display("FAIL reset_wait_next: got %h after %0d expected 0000000e after 6", div_result, cyc);
        end
        leave();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_staggered();
        test_back_to_back();
        test_flush();
        test_reset_wait();
        repeat (2) @(negedge clk);
        checks++;
        if (axi_viol !== 0) begin fails++; $display("FAIL axi_valid_hold: got %0d drops expected 0", axi_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
